axi_wr_rr_arbiter: RTL and testbench
====================================

// Module: axi_wr_rr_arbiter
// PURPOSE
// Arbitrates the AXI4 write path (AW, W, B) of NB_MASTER bus masters onto one slave port.
// Masters are core data, debug and SPI-slave DMA. One burst is active at a time.
// Slave-side ID is {master index, master ID}; the B response is routed back using the upper index bits.
// Sits in front of a shared slave (e.g. data memory) beside the AXI node.
// PARAMETERS
// NB_MASTER        3   number of requesting masters (>=2); IW = $clog2(NB_MASTER)
// AXI_ADDR_WIDTH  32   address width
// AXI_DATA_WIDTH  32   data width; STRB = AXI_DATA_WIDTH/8
// AXI_ID_WIDTH     2   master-side ID width; SID = AXI_ID_WIDTH+IW
// MAX_OUTSTANDING  4   max accepted AW not yet answered by B (>=1)
// PORTS
// clk        in   1                      clock
// rst        in   1                      synchronous reset, active-high
// m_awvalid  in   NB_MASTER              AW valid per master
// m_awready  out  NB_MASTER              AW ready per master
// m_aw       in   NB_MASTER*(ID+8+ADDR)  packed {awid,awlen,awaddr} per master, master i at slice i
// m_wvalid   in   NB_MASTER              W valid per master
// m_wready   out  NB_MASTER              W ready per master
// m_w        in   NB_MASTER*(1+STRB+DATA) packed {wlast,wstrb,wdata} per master
// m_bvalid   out  NB_MASTER              B valid per master
// m_bready   in   NB_MASTER              B ready per master
// m_b        out  NB_MASTER*(ID+2)       packed {bid,bresp}; bid = low AXI_ID_WIDTH bits of s_b id
// s_awvalid  out  1                      slave AW valid
// s_awready  in   1                      slave AW ready
// s_aw       out  SID+8+ADDR             {{idx,awid},awlen,awaddr}
// s_wvalid   out  1 / s_wready in 1 / s_w out 1+STRB+DATA   slave W channel
// s_bvalid   in   1 / s_bready out 1 / s_b in SID+2         slave B channel
// BEHAVIOUR
// - FSM IDLE -> ADDR -> DATA -> IDLE; state, grant idx g, RR pointer and cnt are registered.
// - IDLE: if any m_awvalid and cnt<MAX_OUTSTANDING, latch g (RR search from pointer, cyclic) -> ADDR.
//   Otherwise stay. Request-to-s_awvalid latency is 1 cycle.
// - ADDR: s_awvalid=1; s_aw=m_aw[g] with idx g prepended; m_awready[g]=s_awready.
//   On handshake: pointer<=g+1 (wraps NB_MASTER-1 -> 0), cnt++, go to DATA.
// - DATA: s_wvalid=m_wvalid[g], s_w=m_w[g], m_wready[g]=s_wready.
//   Handshake with wlast=1 -> IDLE. Next grant is no earlier than the following cycle.
// - Non-granted masters: m_awready=m_wready=0 in every state. s_aw/s_w are 0 when their valid is 0.
// - B path is combinational and independent of FSM. k=s_b id[SID-1:AXI_ID_WIDTH].
//   m_bvalid[k]=s_bvalid; s_bready=m_bready[k]; all other m_bvalid are 0.
//   If k>=NB_MASTER: s_bready=1, response dropped.
// - cnt width $clog2(MAX_OUTSTANDING+1). Increments on AW handshake, decrements on B handshake, both -> unchanged.
//   cnt==MAX_OUTSTANDING only blocks new grants in IDLE.
// - A master dropping m_awvalid/m_wvalid before ready is a protocol violation. It is not checked or recovered.
// - Reset: state IDLE, g=0, pointer=0, cnt=0. s_awvalid, s_wvalid and all m_awready/m_wready are 0.
//   s_bready and m_bvalid stay combinational from inputs.
//   Reset mid-burst abandons the burst; the slave shares the same reset.
// CONFIGURATION
// AXI_ARB_FIXED_PRIO_EN defined: IDLE grants the lowest-index requesting master; pointer held at 0.
// AXI_ARB_FIXED_PRIO_EN undefined (default): round-robin as above.
// TESTING
// 1 rst=1 with all m_awvalid=1 -> s_awvalid=0, m_awready=0, m_wready=0. After release, first grant is master 0.
// 2 NB=3, all request 1-beat writes, slave always ready -> s_aw idx sequence 0,1,2,0. Each AW appears 1 cycle after IDLE.
// 3 m1 awlen=3, m0 requests during m1 burst -> m0 AW not issued until m1's 4th beat (wlast) accepted.
//   s_w carries only m1 data meanwhile.
// 4 MAX=2, s_bvalid=0, three writes -> third AW held in IDLE.
//   Then B with s_b id={2'd0,2'd3} -> m_bvalid[0]=1, m_b bid=3; third AW granted the next cycle.
// 5 cnt=1, AW and B handshakes in the same cycle -> cnt stays 1.
//   B with idx=3 (NB=3) -> s_bready=1, no m_bvalid.
// 6 AXI_ARB_FIXED_PRIO_EN, m0 and m2 requesting continuously -> every grant is idx 0; m2 never granted.

Source files
------------

// File: rtl/axi_wr_rr_arbiter.sv
// AXI4 write-path arbiter: NB_MASTER masters onto one slave, one burst at a time.
// Define AXI_ARB_FIXED_PRIO_EN for lowest-index-first instead of round-robin.
module axi_wr_rr_arbiter #(
  parameter int NB_MASTER       = 3,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int AXI_ID_WIDTH    = 2,
  parameter int MAX_OUTSTANDING = 4,
  localparam int IW   = $clog2(NB_MASTER),
  localparam int STRB = AXI_DATA_WIDTH / 8,
  localparam int SID  = AXI_ID_WIDTH + IW,
  localparam int AWW  = AXI_ID_WIDTH + 8 + AXI_ADDR_WIDTH,
  localparam int WW   = 1 + STRB + AXI_DATA_WIDTH,
  localparam int BW   = AXI_ID_WIDTH + 2,
  localparam int SAW  = SID + 8 + AXI_ADDR_WIDTH,
  localparam int SBW  = SID + 2,
  localparam int CW   = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NB_MASTER-1:0]    m_awvalid,
  output logic [NB_MASTER-1:0]    m_awready,
  input  logic [NB_MASTER*AWW-1:0] m_aw,
  input  logic [NB_MASTER-1:0]    m_wvalid,
  output logic [NB_MASTER-1:0]    m_wready,
  input  logic [NB_MASTER*WW-1:0] m_w,
  output logic [NB_MASTER-1:0]    m_bvalid,
  input  logic [NB_MASTER-1:0]    m_bready,
  output logic [NB_MASTER*BW-1:0] m_b,
  output logic                    s_awvalid,
  input  logic                    s_awready,
  output logic [SAW-1:0]          s_aw,
  output logic                    s_wvalid,
  input  logic                    s_wready,
  output logic [WW-1:0]           s_w,
  input  logic                    s_bvalid,
  output logic                    s_bready,
  input  logic [SBW-1:0]          s_b
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   g_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   ptr_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            awv_q;

  logic [AWW-1:0]  aw_sel;
  logic [WW-1:0]   w_sel;
  logic            wlast;
  logic            aw_hs;
  logic            w_hs;
  logic            b_hs;
  logic            can_grant;
  logic [IW-1:0]   start;
  logic [IW-1:0]   pick;
  logic            found;
  logic [IW:0]     j;
  logic [IW-1:0]   bk;
  logic            b_ok;

  assign aw_sel = m_aw[g_q*AWW +: AWW];
  assign w_sel  = m_w[g_q*WW +: WW];
  assign wlast  = w_sel[WW-1];

  assign s_awvalid = awv_q;
  assign s_aw      = awv_q ? {g_q, aw_sel} : '0;
  assign s_wvalid  = (state_q == DATA) && m_wvalid[g_q];
  assign s_w       = s_wvalid ? w_sel : '0;

  assign aw_hs = awv_q && s_awready;
  assign w_hs  = s_wvalid && s_wready;
  assign b_hs  = s_bvalid && s_bready;

  assign can_grant = (|m_awvalid) && (cnt_q < CW'(MAX_OUTSTANDING));

  always_comb begin
    m_awready = '0;
    m_wready  = '0;
    m_awready[g_q] = awv_q && s_awready;
    m_wready[g_q]  = (state_q == DATA) && s_wready;
  end

`ifdef AXI_ARB_FIXED_PRIO_EN
  assign start = '0;
  assign ptr_d = '0;
`else
  assign start = ptr_q;
  assign ptr_d = (g_q == IW'(NB_MASTER - 1)) ? '0 : g_q + 1'b1;
`endif

  // cyclic search starting at 'start'
  always_comb begin
    pick  = start;
    found = 1'b0;
    j     = '0;
    for (int i = 0; i < NB_MASTER; i++) begin
      j = {1'b0, start} + (IW+1)'(i);
      if (j >= (IW+1)'(NB_MASTER)) begin
        j = j - (IW+1)'(NB_MASTER);
      end
      if (!found && m_awvalid[j[IW-1:0]]) begin
        found = 1'b1;
        pick  = j[IW-1:0];
      end
    end
  end

  // responses bypass the FSM; unknown index is absorbed
  assign bk   = s_b[SBW-1 -: IW];
  assign b_ok = {1'b0, bk} < (IW+1)'(NB_MASTER);
  assign m_b  = {NB_MASTER{s_b[BW-1:0]}};

  always_comb begin
    m_bvalid = '0;
    s_bready = 1'b1;
    if (b_ok) begin
      m_bvalid[bk] = s_bvalid;
      s_bready     = m_bready[bk];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({aw_hs, b_hs})
      2'b10: cnt_d = cnt_q + 1'b1;
      2'b01: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      awv_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      unique case (state_q)
        IDLE: begin
          if (can_grant) begin
            g_q     <= pick;
            awv_q   <= 1'b1;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (s_awready) begin
            awv_q   <= 1'b0;
            ptr_q   <= ptr_d;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (w_hs && wlast) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_rr_arbiter.sv
// Directed bench for axi_wr_rr_arbiter with a behavioural master/slave model.
// Fixed-priority expectations are selected by AXI_ARB_FIXED_PRIO_EN.
module tb_axi_wr_rr_arbiter;

  localparam int NB   = 3;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int IDW  = 2;
  localparam int MAXO = 2;
  localparam int IW   = 2;
  localparam int SID  = IDW + IW;
  localparam int AWW  = IDW + 8 + AW;
  localparam int WW   = 1 + 4 + DW;
  localparam int BW   = IDW + 2;
  localparam int SAW  = SID + 8 + AW;
  localparam int SBW  = SID + 2;

`ifdef AXI_ARB_FIXED_PRIO_EN
  localparam int EXP2[4] = '{0, 0, 1, 2};
  localparam int EXP5A   = 0;
  localparam int EXP5B   = 2;
`else
  localparam int EXP2[4] = '{0, 1, 2, 0};
  localparam int EXP5A   = 2;
  localparam int EXP5B   = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NB-1:0]     m_awvalid, m_awready, m_wvalid, m_wready;
  logic [NB-1:0]     m_bvalid, m_bready;
  logic [NB*AWW-1:0] m_aw;
  logic [NB*WW-1:0]  m_w;
  logic [NB*BW-1:0]  m_b;
  logic              s_awvalid, s_awready, s_wvalid, s_wready;
  logic              s_bvalid, s_bready;
  logic [SAW-1:0]    s_aw;
  logic [WW-1:0]     s_w;
  logic [SBW-1:0]    s_b;

  axi_wr_rr_arbiter #(
    .NB_MASTER(NB), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
    .AXI_ID_WIDTH(IDW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_aw(m_aw),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_w(m_w),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_b(m_b),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_aw(s_aw),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_w(s_w),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_b(s_b)
  );

  int checks = 0;
  int errors = 0;

  int nreq[NB];
  int len[NB];
  int beat[NB];
  logic [IDW-1:0] mid[NB];

  int cyc = 0;
  int last_cyc = 0;
  int aw_idx[$];
  int aw_cyc[$];
  logic [DW-1:0] wdat[$];
  logic wlst[$];
  logic auto_b = 1'b0;
  logic [SID-1:0] cur_sid;
  logic [SID-1:0] bq[$];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NB; i++) begin
      m_aw[i*AWW +: AWW] = {mid[i], 8'(len[i]), 32'(32'h1000 * (i + 1))};
      m_w[i*WW +: WW] = {beat[i] == len[i], 4'hF, 32'(i * 256 + beat[i])};
    end
  endtask

  // sample just before the edge, then update the model after it
  task automatic tick();
    logic [NB-1:0] haw, hw;
    logic hb;
    #1;
    haw = m_awvalid & m_awready;
    hw  = m_wvalid & m_wready;
    hb  = s_bvalid & s_bready;
    if (s_awvalid && s_awready) begin
      aw_idx.push_back(int'(s_aw[SAW-1 -: IW]));
      aw_cyc.push_back(cyc);
      cur_sid = s_aw[SAW-1 -: SID];
    end
    if (s_wvalid && s_wready) begin
      wdat.push_back(s_w[DW-1:0]);
      wlst.push_back(s_w[WW-1]);
      if (s_w[WW-1]) begin
        last_cyc = cyc;
        if (auto_b) bq.push_back(cur_sid);
      end
    end
    if (auto_b && hb && bq.size() > 0) void'(bq.pop_front());
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NB; i++) begin
      if (haw[i]) begin
        m_awvalid[i] = 1'b0;
        m_wvalid[i]  = 1'b1;
        beat[i]      = 0;
      end else if (hw[i]) begin
        if (beat[i] == len[i]) begin
          m_wvalid[i] = 1'b0;
          nreq[i]--;
          if (nreq[i] > 0) m_awvalid[i] = 1'b1;
        end else begin
          beat[i]++;
        end
      end
    end
    if (auto_b) begin
      s_bvalid = bq.size() > 0;
      s_b = s_bvalid ? {bq[0], 2'b00} : '0;
    end
    drive();
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_aw(string tag, int n, int budget);
    int k = 0;
    while (aw_idx.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(tag, aw_idx.size(), n);
  endtask

  task automatic reset_all();
    rst = 1'b1;
    m_awvalid = '0;
    m_wvalid = '0;
    s_bvalid = 1'b0;
    s_b = '0;
    m_bready = '1;
    for (int i = 0; i < NB; i++) begin
      nreq[i] = 0; len[i] = 0; beat[i] = 0;
    end
    drive();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    aw_idx.delete(); aw_cyc.delete();
    wdat.delete(); wlst.delete(); bq.delete();
  endtask

  initial begin
    int k;
    rst = 1'b1;
    s_awready = 1'b1;
    s_wready = 1'b1;
    s_bvalid = 1'b0;
    s_b = '0;
    m_bready = '1;
    m_wvalid = '0;
    for (int i = 0; i < NB; i++) begin
      nreq[i] = 1; len[i] = 0; beat[i] = 0; mid[i] = IDW'(i);
    end
    nreq[0] = 2;
    mid[0] = 2'd3;
    m_awvalid = '1;
    drive();

    // reset with every master requesting
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_awvalid", s_awvalid, 0);
    chk("rst_awready", m_awready, 0);
    chk("rst_wready", m_wready, 0);
    chk("rst_wvalid", s_wvalid, 0);

    // release; round-robin of 1-beat writes
    rst = 1'b0;
    auto_b = 1'b1;
    tick();
    #1;
    chk("first_awvalid", s_awvalid, 1);
    chk("first_idx", s_aw[SAW-1 -: IW], 0);
    wait_aw("rr_count", 4, 40);
    for (int i = 0; i < 4; i++) begin
      if (i < aw_idx.size()) chk("rr_idx", aw_idx[i], EXP2[i]);
      if (i > 0 && i < aw_cyc.size())
        chk("rr_gap", aw_cyc[i] - aw_cyc[i-1], 3);
    end
    ticks(6);

    // long burst from m1 blocks m0
    reset_all();
    nreq[1] = 1; len[1] = 3; m_awvalid[1] = 1'b1;
    drive();
    wait_aw("burst_aw1", 1, 10);
    nreq[0] = 1; len[0] = 0; m_awvalid[0] = 1'b1;
    drive();
    wait_aw("burst_aw2", 2, 20);
    if (aw_idx.size() == 2) begin
      chk("burst_idx", aw_idx[1], 0);
      chk("burst_gap", aw_cyc[1] - last_cyc, 2);
    end
    ticks(4);
    chk("burst_wcnt", wdat.size(), 5);
    if (wdat.size() == 5) begin
      for (int i = 0; i < 4; i++) chk("burst_wdat", wdat[i], 256 + i);
      chk("burst_wlst2", wlst[2], 0);
      chk("burst_wlst3", wlst[3], 1);
      chk("burst_m0dat", wdat[4], 0);
    end

    // outstanding limit
    reset_all();
    auto_b = 1'b0;
    for (int i = 0; i < NB; i++) begin
      nreq[i] = 1; m_awvalid[i] = 1'b1;
    end
    drive();
    ticks(15);
    chk("lim_count", aw_idx.size(), 2);
    #1;
    chk("lim_awvalid", s_awvalid, 0);
    m_bready[0] = 1'b0;
    s_bvalid = 1'b1;
    s_b = {2'd0, 2'd3, 2'b00};
    #1;
    chk("b_ready_fwd0", s_bready, 0);
    chk("b_valid_route", m_bvalid, 3'b001);
    chk("b_bid", m_b[BW-1 -: IDW], 3);
    tick();
    m_bready[0] = 1'b1;
    #1;
    chk("b_ready_fwd1", s_bready, 1);
    tick();
    s_bvalid = 1'b0;
    #1;
    chk("lim_wait", s_awvalid, 0);
    tick();
    #1;
    chk("lim_grant", s_awvalid, 1);
    chk("lim_idx", s_aw[SAW-1 -: IW], 2);
    ticks(4);

    // simultaneous AW and B keep the count
    reset_all();
    nreq[0] = 1; m_awvalid[0] = 1'b1;
    drive();
    wait_aw("sim_aw1", 1, 10);
    ticks(4);
    nreq[1] = 1; m_awvalid[1] = 1'b1;
    drive();
    k = 0;
    while (!s_awvalid && k < 10) begin
      tick();
      k++;
    end
    chk("sim_addr", s_awvalid, 1);
    s_bvalid = 1'b1;
    s_b = {2'd0, mid[0], 2'b00};
    tick();
    s_bvalid = 1'b0;
    s_b = '0;
    ticks(6);
    nreq[2] = 1; m_awvalid[2] = 1'b1;
    nreq[0] = 1; m_awvalid[0] = 1'b1;
    drive();
    ticks(15);
    chk("sim_count", aw_idx.size(), 3);
    if (aw_idx.size() >= 3) chk("sim_idx", aw_idx[2], EXP5A);

    // response to a non-existent master is absorbed
    m_bready = '0;
    s_bvalid = 1'b1;
    s_b = {2'd3, 2'd0, 2'b00};
    #1;
    chk("drop_ready", s_bready, 1);
    chk("drop_valid", m_bvalid, 0);
    tick();
    s_bvalid = 1'b0;
    m_bready = '1;
    ticks(5);
    chk("drop_count", aw_idx.size(), 4);
    if (aw_idx.size() >= 4) chk("drop_idx", aw_idx[3], EXP5B);
    ticks(4);

`ifdef AXI_ARB_FIXED_PRIO_EN
    reset_all();
    auto_b = 1'b1;
    nreq[0] = 4; m_awvalid[0] = 1'b1;
    nreq[2] = 4; m_awvalid[2] = 1'b1;
    drive();
    wait_aw("fix_count", 4, 40);
    for (int i = 0; i < aw_idx.size(); i++) chk("fix_idx", aw_idx[i], 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
